// File: rtl/instr_queue_pkg.sv
// Shared defaults and entry layout for the fetch-to-decode instruction queue.
package instr_queue_pkg;

  localparam int IQ_XLEN_DEF  = 32;
  localparam int IQ_DEPTH_DEF = 4;

  typedef struct packed {
    logic [IQ_XLEN_DEF-1:0] pc;
    logic [IQ_XLEN_DEF-1:0] pc_plus_four;
    logic [IQ_XLEN_DEF-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_iq_ram.sv
// Entry storage for instr_queue: DEPTH x W register array, one write port,
// one asynchronous read port. Contents are never reset.
module iq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode with flush support.
// Optional same-cycle empty-queue bypass when IQ_BYPASS_EN is defined.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEF,
  parameter int XLEN  = IQ_XLEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pc_plus_four,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc_plus_four,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_four;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  entry_t        r_last;

  entry_t w_in;
  entry_t w_head;
  entry_t w_cur;
  logic   w_empty;
  logic   w_full;
  logic   w_byp;
  logic   w_out_valid;
  logic   w_pop;
  logic   w_push;
  logic   w_in_ready;
  logic   w_byp_take;
  logic   w_wr;
  logic   w_rd;

  assign w_in    = '{pc: in_pc, pc_plus_four: in_pc_plus_four, instr: in_instr};
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

`ifdef IQ_BYPASS_EN
  assign w_byp = w_empty && in_valid;
`else
  assign w_byp = 1'b0;
`endif

  // Bypassed entries consumed in the same cycle never touch storage or pointers.
  always_comb begin
    w_out_valid = (!w_empty || w_byp) && !flush;
    w_pop       = w_out_valid && out_ready;
    w_in_ready  = !w_full || w_pop;
    w_push      = in_valid && w_in_ready;
    w_byp_take  = w_byp && w_pop;
    w_wr        = w_push && !flush && !w_byp_take;
    w_rd        = w_pop && !w_byp_take;
    w_cur       = w_byp ? w_in : w_head;
  end

  iq_ram #(
    .DEPTH (DEPTH),
    .W     (3*XLEN)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (w_in),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Last presented head, so the data ports hold while out_valid is low.
  always_ff @(posedge clk) begin
    if (w_out_valid) r_last <= w_cur;
  end

  entry_t w_out;
  assign w_out = w_out_valid ? w_cur : r_last;

  assign in_ready         = w_in_ready;
  assign out_valid        = w_out_valid;
  assign out_pc           = w_out.pc;
  assign out_pc_plus_four = w_out.pc_plus_four;
  assign out_instr        = w_out.instr;
  assign count            = r_count;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue (DEPTH=4, XLEN=32); bypass case follows IQ_BYPASS_EN.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_pc_plus_four;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_four;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_pc            (in_pc),
    .in_pc_plus_four  (in_pc_plus_four),
    .in_instr         (in_instr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_pc_plus_four (out_pc_plus_four),
    .out_instr        (out_instr),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid        = v;
    in_pc           = pc;
    in_pc_plus_four = pc + 32'd4;
    in_instr        = pc ^ 32'hA5A5_0000;
  endtask

  // Pop one entry and check its fields against the expected PC.
  task automatic pop_check(input string tag, input logic [31:0] pc);
    out_ready = 1'b1;
    #1;
    check_eq({tag, "_valid"}, out_valid, 1'b1);
    check_eq({tag, "_pc"},    out_pc, pc);
    check_eq({tag, "_pc4"},   out_pc_plus_four, pc + 32'd4);
    check_eq({tag, "_instr"}, out_instr, pc ^ 32'hA5A5_0000);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    #12;
    check_eq("rst_count", count, 0);
    check_eq("rst_out_valid", out_valid, 0);
    rst = 1'b1;
    step();
    check_eq("rst_in_ready", in_ready, 1);

    // Fill to full with out_ready low
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i*4));
      #1;
      check_eq("fill_in_ready", in_ready, 1);
      check_eq("fill_count", count, 64'(i));
      step();
    end
    drive(1'b1, 32'h10);
    #1;
    check_eq("full_count", count, 4);
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_head", out_pc, 32'h0);
    step();
    check_eq("stall_count", count, 4);
    drive(1'b0, 32'h0);

    // Pop two, push two (write pointer wraps), then drain
    pop_check("pop0", 32'h0);
    pop_check("pop1", 32'h4);
    out_ready = 1'b0;
    check_eq("mid_count", count, 2);
    drive(1'b1, 32'h10); step();
    drive(1'b1, 32'h14); step();
    drive(1'b0, 32'h0);
    check_eq("refill_count", count, 4);
    pop_check("wrap0", 32'h8);
    pop_check("wrap1", 32'hC);
    pop_check("wrap2", 32'h10);
    pop_check("wrap3", 32'h14);
    out_ready = 1'b0;
    #1;
    check_eq("drained_count", count, 0);
    check_eq("drained_valid", out_valid, 0);
    check_eq("hold_pc", out_pc, 32'h14);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h20 + 32'(i*4));
      step();
    end
    drive(1'b1, 32'h30);
    out_ready = 1'b1;
    #1;
    check_eq("pp_in_ready", in_ready, 1);
    check_eq("pp_head0", out_pc, 32'h20);
    step();
    drive(1'b0, 32'h0);
    out_ready = 1'b0;
    check_eq("pp_count", count, 4);
    check_eq("pp_head1", out_pc, 32'h24);
    pop_check("pp_d0", 32'h24);
    pop_check("pp_d1", 32'h28);
    pop_check("pp_d2", 32'h2C);
    pop_check("pp_d3", 32'h30);
    out_ready = 1'b0;

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(i*4));
      step();
    end
    check_eq("pre_flush_count", count, 3);
    drive(1'b1, 32'h4C);
    flush = 1'b1;
    #1;
    check_eq("flush_valid_now", out_valid, 0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    check_eq("flush_count", count, 0);
    check_eq("flush_valid", out_valid, 0);
    drive(1'b1, 32'h50);
    step();
    drive(1'b0, 32'h0);
    check_eq("post_flush_count", count, 1);
    pop_check("post_flush", 32'h50);
    out_ready = 1'b0;

    // Asynchronous reset mid-cycle
    drive(1'b1, 32'h60); step();
    drive(1'b1, 32'h64); step();
    drive(1'b0, 32'h0);
    check_eq("pre_rst_count", count, 2);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_count", count, 0);
    check_eq("arst_valid", out_valid, 0);
    #1;
    rst = 1'b1;
    step();
    check_eq("arst_in_ready", in_ready, 1);
    check_eq("arst_count_after", count, 0);

    // Empty-queue latency / bypass
    in_valid = 1'b1; in_pc = 32'h70; in_pc_plus_four = 32'h74; in_instr = 32'h0000_0013;
    out_ready = 1'b1;
    #1;
`ifdef IQ_BYPASS_EN
    check_eq("byp_valid", out_valid, 1);
    check_eq("byp_instr", out_instr, 32'h0000_0013);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("byp_count", count, 0);
    check_eq("byp_valid_after", out_valid, 0);
`else
    check_eq("lat_valid_now", out_valid, 0);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("lat_valid_next", out_valid, 1);
    check_eq("lat_instr", out_instr, 32'h0000_0013);
    check_eq("lat_count", count, 1);
    step();
    check_eq("lat_count_after", count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
